store_sequencer: RTL and testbench
==================================

STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the memory word and store data width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, the memory address width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 req  input  1  store request, qualified by ready.
REQ-006 req_addr  input  ADDR_W  store target address, passed to memory unmodified.
REQ-007 req_data  input  DATA_W  register source data (RegB equivalent).
REQ-008 req_size  input  2  1=byte, 2=halfword, 3=word, 0=illegal.
REQ-009 ready  output  1  high only in IDLE; request accepted when req && ready.
REQ-010 mem_addr  output  ADDR_W  memory address.
REQ-011 mem_rd  output  1  memory read strobe.
REQ-012 mem_wr  output  1  memory write strobe.
REQ-013 mem_wdata  output  DATA_W  memory write data.
REQ-014 mem_rdata  input  DATA_W  memory read data, valid exactly one cycle after the mem_rd cycle.
REQ-015 done  output  1  one-cycle pulse at completion of an accepted store.
REQ-016 err  output  1  one-cycle pulse when an illegal size is accepted.

Function
REQ-017 States SHALL be IDLE, READ, WAIT, WRITE and DONE.
REQ-018 On acceptance, req_addr, req_data and req_size SHALL be latched; later input changes SHALL not affect the operation.
REQ-019 Acceptance transitions:
- size 1 or 2: IDLE->READ.
- size 3: IDLE->WRITE.
- size 0: IDLE->DONE with err=1 in DONE, no memory access.
REQ-020 READ: mem_rd=1, mem_addr=latched address; next state WAIT.
REQ-021 WAIT: mem_rdata SHALL be captured into an internal word register; next state WRITE.
REQ-022 WRITE: mem_wr=1 for exactly one cycle, mem_addr=latched address; next state DONE.
REQ-023 mem_wdata in WRITE SHALL be:
- byte: {captured[31:8], data[7:0]}.
- half: {captured[31:16], data[15:0]}.
- word: data.
REQ-024 DONE: done=1 for one cycle; next state IDLE.
REQ-025 Latency from acceptance edge to done SHALL be 4 cycles for byte/half, 2 cycles for word, and 1 cycle for illegal size.
REQ-026 The next request SHALL be acceptable no earlier than the cycle after DONE.
REQ-027 req asserted while ready=0 SHALL be ignored, not queued.
REQ-028 Outside READ, mem_rd SHALL be 0; outside WRITE, mem_wr SHALL be 0; mem_rd and mem_wr SHALL never both be 1.
REQ-029 mem_addr and mem_wdata SHALL hold their last values when their strobe is low.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from req to mem_*.

Reset
REQ-031 reset SHALL force IDLE.
REQ-032 reset SHALL set ready=1 and clear mem_rd, mem_wr, done, err, mem_addr, mem_wdata and the captured word.
REQ-033 reset asserted in any state SHALL abort the operation, with no write issued in the following cycle.
REQ-034 reset SHALL take priority over req in the same cycle.

Structure
REQ-035 A shared package SHALL hold the size encodings (SZ_ILL=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3) and the state enumeration.
REQ-036 Lane merging SHALL be a combinational sub-module named store_merge; the sequencer SHALL contain only control and latching logic.

Verification
REQ-037 Byte store: mem word 0xAABBCCDD, data 0x12345678, size 1, addr 0x40 -> mem_rd at cycle 1, mem_wr at cycle 3 with mem_wdata 0xAABBCC78, done at cycle 4.
REQ-038 Half store: mem word 0xAABBCCDD, data 0x12345678, size 2 -> mem_wdata 0xAABB5678, mem_rd pulse seen once.
REQ-039 Word store: data 0xCAFEF00D, size 3 -> no mem_rd, mem_wr at cycle 1 with 0xCAFEF00D, done at cycle 2.
REQ-040 Illegal size: size 0 -> err and done at cycle 1, mem_rd and mem_wr never high.
REQ-041 Back-to-back: req held high across two byte stores with req_data changed mid-operation -> first write uses latched data, second accepted only after DONE.
REQ-042 Reset during WAIT of a byte store -> mem_wr stays 0 and ready=1 on the next cycle.

Source files
------------

// File: rtl/store_sequencer_pkg.sv
// store_sequencer_pkg: size encodings and sequencer state enumeration shared by the store sequencer files
package store_sequencer_pkg;
  typedef enum logic [1:0] {
    SZ_ILL  = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;
endpackage

// File: rtl/store_merge.sv
// store_merge: overlays the low byte/halfword/word of data onto word according to size (word, data, size in; merged out)
module store_merge
  import store_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] data,
  input  size_e             size,
  output logic [DATA_W-1:0] merged
);
  logic [DATA_W-1:0] mask;
  always_comb begin
    mask   = size == SZ_BYTE ? DATA_W'(16'h00ff) : size == SZ_HALF ? DATA_W'(16'hffff) : '1;
    merged = (word & ~mask) | (data & mask);
  end
endmodule

// File: rtl/store_sequencer.sv
// store_sequencer: read-modify-write store sequencer (req/req_addr/req_data/req_size/ready handshake; mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata memory side; done/err pulses)
module store_sequencer
  import store_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              err
);
  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merged;
  logic              accept;
  store_merge #(.DATA_W(DATA_W)) u_merge (
    .word  (word_q),
    .data  (data_q),
    .size  (size_q),
    .merged(merged)
  );
  always_comb begin
    accept  = req && state_q == S_IDLE;
    state_d = state_q == S_IDLE  ? (!req ? S_IDLE : req_size == SZ_ILL ? S_DONE :
                                    req_size == SZ_WORD ? S_WRITE : S_READ) :
              state_q == S_READ  ? S_WAIT :
              state_q == S_WAIT  ? S_WRITE :
              state_q == S_WRITE ? S_DONE : S_IDLE;
    // an illegal store never touches memory, so the visible address must not move
    addr_d  = accept && req_size != SZ_ILL ? req_addr : addr_q;
    data_d  = accept ? req_data : data_q;
    size_d  = accept ? size_e'(req_size) : size_q;
    word_d  = state_q == S_WAIT ? mem_rdata : word_q;
    wdata_d = mem_wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      size_q  <= SZ_ILL;
      addr_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
    end
  end
  assign ready     = state_q == S_IDLE;
  assign mem_rd    = state_q == S_READ;
  assign mem_wr    = state_q == S_WRITE;
  assign done      = state_q == S_DONE;
  assign err       = done && size_q == SZ_ILL;
  assign mem_addr  = addr_q;
  // merge inputs are all registered; the register only remembers the last written word
  assign mem_wdata = mem_wr ? merged : wdata_q;
endmodule

// File: tb/tb_store_sequencer.sv
// tb_store_sequencer: randomized and directed self-checking bench for store_sequencer
module tb_store_sequencer;
  logic        clk = 0;
  logic        reset;
  logic        req;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        ready;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_addr = 0;
  logic [31:0] last_wdata = 0;

  store_sequencer #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_size (req_size),
    .ready    (ready),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_wdata(input logic [31:0] mem, input logic [31:0] data,
                                              input logic [1:0] size);
    case (size)
      2'd1:    return {mem[31:8], data[7:0]};
      2'd2:    return {mem[31:16], data[15:0]};
      default: return data;
    endcase
  endfunction

  // One store: wait for ready, issue it, observe every cycle until done, then one idle cycle.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] w,
                       input logic [1:0] s, input bit hold);
    int wait_n = 0;
    int lat = (s == 2'd3) ? 2 : (s == 2'd0) ? 1 : 4;
    int exp_rd_at = (s == 2'd1 || s == 2'd2) ? 1 : 0;
    int exp_wr_at = (s == 2'd0) ? 0 : lat - 1;
    int rd_at = 0, wr_at = 0, done_at = 0, rd_n = 0, wr_n = 0;
    logic [31:0] wd = 0;
    logic err_done = 0;
    logic prev_rd = 0;
    bit bad_ready = 0, both = 0, bad_addr = 0, bad_err = 0;
    while (!ready && wait_n < 8) begin
      step();
      wait_n++;
    end
    check("ready_before_req", ready, 1);
    req = 1; req_addr = a; req_data = d; req_size = s;
    step();
    if (!hold) req = 0;
    req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
    for (int k = 1; k <= 8; k++) begin
      if (mem_rd) begin
        rd_n++;
        if (rd_at == 0) rd_at = k;
        if (mem_addr !== a) bad_addr = 1;
      end
      if (mem_wr) begin
        wr_n++;
        wr_at = k;
        wd = mem_wdata;
        if (mem_addr !== a) bad_addr = 1;
      end
      if (mem_rd && mem_wr) both = 1;
      if (ready) bad_ready = 1;
      if (err && !done) bad_err = 1;
      if (done) begin
        done_at = k;
        err_done = err;
        break;
      end
      mem_rdata = prev_rd ? w : $urandom;
      prev_rd = mem_rd;
      step();
    end
    if (s != 2'd0) begin
      last_addr = a;
      last_wdata = model_wdata(w, d, s);
    end
    check("done_latency", done_at, lat);
    check("err_at_done", err_done, s == 2'd0);
    check("rd_cycle", rd_at, exp_rd_at);
    check("rd_count", rd_n, exp_rd_at != 0);
    check("wr_cycle", wr_at, exp_wr_at);
    check("wr_count", wr_n, s != 2'd0);
    if (s != 2'd0) check("wdata", wd, last_wdata);
    check("mem_addr_during_strobe", bad_addr, 0);
    check("rd_wr_overlap", both, 0);
    check("ready_while_busy", bad_ready, 0);
    check("err_outside_done", bad_err, 0);
    step();
    check("ready_after_done", ready, 1);
    check("idle_strobes", {mem_rd, mem_wr, done, err}, 4'b0);
    check("mem_addr_hold", mem_addr, last_addr);
    check("mem_wdata_hold", mem_wdata, last_wdata);
  endtask

  initial begin
    reset = 1; req = 0; req_addr = 0; req_data = 0; req_size = 0; mem_rdata = 0;
    step();
    step();
    check("reset_ready", ready, 1);
    check("reset_strobes", {mem_rd, mem_wr, done, err}, 4'b0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    reset = 0;
    step();
    store(32'h40, 32'h12345678, 32'hAABBCCDD, 2'd1, 0);
    store(32'h44, 32'h12345678, 32'hAABBCCDD, 2'd2, 0);
    store(32'h80, 32'hCAFEF00D, 32'h5A5A5A5A, 2'd3, 0);
    store(32'h100, 32'hDEADBEEF, 32'h01234567, 2'd0, 0);
    store(32'h200, 32'h11111111, 32'hFFFFFFFF, 2'd1, 1);
    store(32'h204, 32'h22223333, 32'hEEEEEEEE, 2'd1, 0);
    // reset while waiting for read data must abort without a write
    store(32'h300, 32'h0000_00AB, 32'h1234_5678, 2'd2, 0);
    req = 1; req_addr = 32'h40; req_data = 32'h12345678; req_size = 2'd1;
    step();
    req = 0;
    step();
    check("rst_wait_in_wait", {mem_rd, mem_wr, ready}, 3'b000);
    reset = 1;
    step();
    reset = 0;
    last_addr = 0;
    last_wdata = 0;
    check("rst_wait_no_write", mem_wr, 0);
    check("rst_wait_ready", ready, 1);
    check("rst_wait_addr", mem_addr, 0);
    check("rst_wait_wdata", mem_wdata, 0);
    step();
    check("rst_wait_still_idle", {mem_wr, mem_rd, done, ready}, 4'b0001);
    // reset wins over a simultaneous word request
    reset = 1; req = 1; req_addr = 32'h500; req_data = 32'h77; req_size = 2'd3;
    step();
    reset = 0; req = 0;
    check("rst_prio_ready", ready, 1);
    check("rst_prio_no_write", mem_wr, 0);
    step();
    check("rst_prio_still_idle", {mem_wr, done}, 2'b00);
    for (int i = 0; i < 30; i++)
      store($urandom, $urandom, $urandom, 2'($urandom), 1'($urandom));
    req = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
